// File: rtl/pipe_hold_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_defs
// Shared definitions for the pipeline hold/flush sequencer of the 4-register
// in-order core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - stage index constants (bit position of each pipe register in stall/flush)
//   - FSM state encodings for the interrupt drain sequence
//   - stall/flush patterns built from the stage indices
//   - default number of drain bubbles before interrupt entry
// -----------------------------------------------------------------------------
package pipe_ctrl_defs;

    // Stage index = bit position in the stall/flush vectors
    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    localparam logic [3:0] BIT_IFID  = 4'b0001 << IFID;
    localparam logic [3:0] BIT_IDEX  = 4'b0001 << IDEX;
    localparam logic [3:0] BIT_EXMEM = 4'b0001 << EXMEM;
    localparam logic [3:0] BIT_MEMWB = 4'b0001 << MEMWB;

    // FSM state encodings
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ENTER = 2'd2;

    // Stall patterns: bus wait freezes everything upstream of MEM/WB,
    // EX busy freezes everything upstream of EX/MEM, a bubble freezes the PC.
    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_BUS  = BIT_IFID | BIT_IDEX | BIT_EXMEM;
    localparam logic [3:0] STALL_EX   = BIT_IFID | BIT_IDEX;
    localparam logic [3:0] STALL_PC   = BIT_IFID;

    // Flush patterns: the first register downstream of a frozen group gets a
    // bubble; a redirect kills the two younger instructions.
    localparam logic [3:0] FLUSH_NONE   = 4'b0000;
    localparam logic [3:0] FLUSH_BUS    = BIT_MEMWB;
    localparam logic [3:0] FLUSH_EX     = BIT_EXMEM;
    localparam logic [3:0] FLUSH_JUMP   = BIT_IFID | BIT_IDEX;
    localparam logic [3:0] FLUSH_BUBBLE = BIT_IFID;

    // Default bubble count inserted before interrupt entry (legal 1..15)
    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipe_hold_ctrl_wdt.sv
// -----------------------------------------------------------------------------
// pipe_stall_wdt
// Bus-stall watchdog: counts consecutive cycles of bus_stall_req and raises a
// sticky error once the run reaches WDT_CYCLES. Cleared only by rst.
// Only instantiated when PIPE_STALL_WDT_EN is defined.
// Ports:
//   clk           in  core clock
//   rst           in  synchronous reset, active-high
//   bus_stall_req in  MEM bus not ready
//   wdt_err       out sticky timeout flag (registered)
// -----------------------------------------------------------------------------
module pipe_stall_wdt #(
    parameter int WDT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic bus_stall_req,
    output logic wdt_err
);

    localparam int            CW       = $clog2(WDT_CYCLES + 1);
    localparam logic [CW-1:0] WDT_MAX  = CW'(WDT_CYCLES);
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          err_r;

    // Consecutive-stall counter (saturating) and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else if (bus_stall_req) begin
            if (cnt_r != WDT_MAX) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            // This cycle is the WDT_CYCLES-th consecutive stall
            if (cnt_r == WDT_LAST) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            cnt_r <= {CW{1'b0}};
            err_r <= err_r;
        end
    end

    assign wdt_err = err_r;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
// Central pipeline sequencer: arbitrates stall requests, redirects and
// interrupt entry, and drives per-stage stall/flush plus the PC write port.
// Interrupts are taken by draining the pipe with DRAIN_CYCLES bubbles, then
// vectoring to irq_vector and pulsing irq_ack one cycle later.
// Optional feature macro: PIPE_STALL_WDT_EN (bus-stall watchdog -> wdt_err).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pc_i                 current fetch PC (captured as return address)
//   jump_req/jump_addr   redirect from EX (level, held until serviced)
//   ex_stall_req         EX multi-cycle unit busy
//   bus_stall_req        MEM bus not ready
//   irq_req/irq_vector   interrupt pending (level) and handler address
//   stall[3:0]           freeze pipe register k; stall[0] also freezes PC
//   flush[3:0]           load bubble into pipe register k
//   pc_we/pc_wdata       PC write strobe and value
//   irq_ack              registered one-cycle interrupt-taken pulse
//   irq_epc              captured interrupt return address
//   wdt_err              sticky bus-stall timeout (0 without the feature)
// stall/flush/pc_we/pc_wdata are combinational from state and requests.
// -----------------------------------------------------------------------------
module pipe_hold_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int AW           = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int WDT_CYCLES   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          jump_req,
    input  logic [AW-1:0] jump_addr,
    input  logic          ex_stall_req,
    input  logic          bus_stall_req,
    input  logic          irq_req,
    input  logic [AW-1:0] irq_vector,
    output logic [3:0]    stall,
    output logic [3:0]    flush,
    output logic          pc_we,
    output logic [AW-1:0] pc_wdata,
    output logic          irq_ack,
    output logic [AW-1:0] irq_epc,
    output logic          wdt_err
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic [AW-1:0] irq_epc_r;
    logic [AW-1:0] epc_nxt_s;
    logic          irq_ack_r;
    logic          ack_nxt_s;
    logic [3:0]    stall_s;
    logic [3:0]    flush_s;
    logic          pc_we_s;
    logic [AW-1:0] pc_wdata_s;
    logic          wdt_err_s;

    // Priority arbitration and FSM next-state; stalls pre-empt every state
    always_comb begin
        stall_s     = STALL_NONE;
        flush_s     = FLUSH_NONE;
        pc_we_s     = 1'b0;
        pc_wdata_s  = {AW{1'b0}};
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        epc_nxt_s   = irq_epc_r;
        ack_nxt_s   = 1'b0;

        if (bus_stall_req) begin
            stall_s = STALL_BUS;
            flush_s = FLUSH_BUS;
        end else if (ex_stall_req) begin
            stall_s = STALL_EX;
            flush_s = FLUSH_EX;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A same-cycle jump wins; the IRQ is taken next cycle
                    if (jump_req) begin
                        flush_s    = FLUSH_JUMP;
                        pc_we_s    = 1'b1;
                        pc_wdata_s = jump_addr;
                    end else if (irq_req) begin
                        stall_s     = STALL_PC;
                        flush_s     = FLUSH_BUBBLE;
                        state_nxt_s = ST_DRAIN;
                        epc_nxt_s   = pc_i;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // PC stays frozen. An older instruction redirecting moves
                    // the return address instead of the PC; it still counts as
                    // a non-stalled drain cycle.
                    stall_s   = STALL_PC;
                    cnt_nxt_s = cnt_r + 4'd1;
                    if (jump_req) begin
                        flush_s   = FLUSH_JUMP;
                        epc_nxt_s = jump_addr;
                    end else begin
                        flush_s = FLUSH_BUBBLE;
                    end
                    if (cnt_r == DRAIN_LAST) begin
                        state_nxt_s = ST_ENTER;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_ENTER: begin
                    flush_s     = FLUSH_JUMP;
                    pc_we_s     = 1'b1;
                    pc_wdata_s  = irq_vector;
                    state_nxt_s = ST_RUN;
                    ack_nxt_s   = 1'b1;
                end
                default: begin
                    // Unused encoding: fall back to normal running
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State, drain counter, return address and acknowledge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            cnt_r     <= 4'd0;
            irq_epc_r <= {AW{1'b0}};
            irq_ack_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            irq_epc_r <= epc_nxt_s;
            irq_ack_r <= ack_nxt_s;
        end
    end

`ifdef PIPE_STALL_WDT_EN
    pipe_stall_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk          (clk),
        .rst          (rst),
        .bus_stall_req(bus_stall_req),
        .wdt_err      (wdt_err_s)
    );
`else
    // Watchdog limit has no meaning without the watchdog
    localparam int unused_wdt_cycles = WDT_CYCLES;
    assign wdt_err_s = 1'b0;
`endif

    assign stall    = stall_s;
    assign flush    = flush_s;
    assign pc_we    = pc_we_s;
    assign pc_wdata = pc_wdata_s;
    assign irq_ack  = irq_ack_r;
    assign irq_epc  = irq_epc_r;
    assign wdt_err  = wdt_err_s;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hold_ctrl
// Directed bench for pipe_hold_ctrl. The stimulus process drives inputs just
// after each rising edge and pushes the hand-computed expected outputs for
// that cycle into a queue; a monitor on the falling edge pops and compares.
// Expected interrupt return addresses go into a second queue that is popped
// whenever the DUT pulses irq_ack.
// Honors PIPE_STALL_WDT_EN (adds the watchdog sequence).
// -----------------------------------------------------------------------------
module tb_pipe_hold_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        ex_stall_req;
    logic        bus_stall_req;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic        irq_ack;
    logic [31:0] irq_epc;
    logic        wdt_err;

    typedef struct {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        we;
        logic [31:0] wdata;
        logic        chk_epc;
        logic [31:0] epc;
        logic        wdt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ack_q[$];
    logic        exp_wdt;
    int          n_cmp;
    int          n_err;

    pipe_hold_ctrl #(
        .AW          (32),
        .DRAIN_CYCLES(3),
        .WDT_CYCLES  (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .jump_req     (jump_req),
        .jump_addr    (jump_addr),
        .ex_stall_req (ex_stall_req),
        .bus_stall_req(bus_stall_req),
        .irq_req      (irq_req),
        .irq_vector   (irq_vector),
        .stall        (stall),
        .flush        (flush),
        .pc_we        (pc_we),
        .pc_wdata     (pc_wdata),
        .irq_ack      (irq_ack),
        .irq_epc      (irq_epc),
        .wdt_err      (wdt_err)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and drive the inputs for it
    task automatic step(input logic r, input logic b, input logic e,
                        input logic j, input logic [31:0] ja, input logic q);
        @(posedge clk);
        #1;
        rst           = r;
        bus_stall_req = b;
        ex_stall_req  = e;
        jump_req      = j;
        jump_addr     = ja;
        irq_req       = q;
    endtask

    // Queue the expected outputs of the current cycle
    task automatic chk(input string nm, input logic [3:0] s, input logic [3:0] f,
                       input logic we, input logic [31:0] wd,
                       input logic ce, input logic [31:0] ep);
        exp_t e;
        e.stall   = s;
        e.flush   = f;
        e.we      = we;
        e.wdata   = wd;
        e.chk_epc = ce;
        e.epc     = ep;
        e.wdt     = exp_wdt;
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations and irq_ack pulses
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (stall !== e.stall || flush !== e.flush || pc_we !== e.we ||
                pc_wdata !== e.wdata || wdt_err !== e.wdt ||
                (e.chk_epc && irq_epc !== e.epc)) begin
                n_err = n_err + 1;
                $display("FAIL %s: got stall=%b flush=%b pc_we=%b pc_wdata=%h epc=%h wdt=%b, want stall=%b flush=%b pc_we=%b pc_wdata=%h epc=%h(chk=%b) wdt=%b",
                         e.name, stall, flush, pc_we, pc_wdata, irq_epc, wdt_err,
                         e.stall, e.flush, e.we, e.wdata, e.epc, e.chk_epc, e.wdt);
            end
        end
        if (irq_ack === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (ack_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_ack: got irq_ack=1 epc=%h, want no ack", irq_epc);
            end else if (irq_epc !== ack_q[0]) begin
                n_err = n_err + 1;
                $display("FAIL ack_epc: got %h, want %h", irq_epc, ack_q[0]);
                void'(ack_q.pop_front());
            end else begin
                void'(ack_q.pop_front());
            end
        end
    end

    // Directed stimulus
    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_wdt       = 1'b0;
        rst           = 1'b1;
        pc_i          = 32'h0000_0040;
        irq_vector    = 32'h0000_0080;
        jump_req      = 1'b0;
        jump_addr     = 32'h0;
        ex_stall_req  = 1'b0;
        bus_stall_req = 1'b0;
        irq_req       = 1'b0;

        // Reset with every request high
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("reset", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0);

        // Jump, then jump held under an EX stall
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        chk("jump", 4'b0000, 4'b0011, 1'b1, 32'h100, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
            chk("jump_under_ex", 4'b0011, 4'b0100, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        chk("jump_after_ex", 4'b0000, 4'b0011, 1'b1, 32'h100, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("idle", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);

        // Bus stall dominates EX stall and jump
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
            chk("bus_ex", 4'b0111, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("idle_after_bus", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);

        // Basic interrupt entry; irq drops during drain and entry completes
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("irq_start", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain0", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain1", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain2", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("enter", 4'b0000, 4'b0011, 1'b1, 32'h80, 1'b0, 32'h0);
        ack_q.push_back(32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("ack_cycle", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h40);

        // Two-cycle bus stall in the middle of the drain
        pc_i = 32'h0000_0044;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("irq2_start", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq2_drain0", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h44);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("irq2_bus", 4'b0111, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("irq2_drain", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq2_enter", 4'b0000, 4'b0011, 1'b1, 32'h80, 1'b0, 32'h0);
        ack_q.push_back(32'h44);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq2_ack", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h44);

        // Jump during drain retargets the return address
        pc_i = 32'h0000_0048;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("irq3_start", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("drain_jump", 4'b0001, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h48);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq3_drain1", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq3_drain2", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq3_enter", 4'b0000, 4'b0011, 1'b1, 32'h80, 1'b0, 32'h0);
        ack_q.push_back(32'h200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq3_ack", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h200);

        // Same-cycle jump and irq in RUN: jump first, irq next cycle
        pc_i = 32'h0000_0180;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h180, 1'b1);
        chk("jump_irq_same", 4'b0000, 4'b0011, 1'b1, 32'h180, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("irq4_start", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("irq4_drain", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h180);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq4_enter", 4'b0000, 4'b0011, 1'b1, 32'h80, 1'b0, 32'h0);
        ack_q.push_back(32'h180);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq4_ack", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h180);

        // Reset during drain aborts entry and clears irq_epc
        pc_i = 32'h0000_0050;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("irq5_start", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("irq5_drain0", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h50);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_in_drain", 4'b0001, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h50);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("after_rst", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0);
        end

`ifdef PIPE_STALL_WDT_EN
        // Watchdog: 255 consecutive bus stalls set the sticky error
        for (int i = 0; i < 255; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("wdt_run", 4'b0111, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        exp_wdt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("wdt_sticky", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wdt_in_rst", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_wdt = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wdt_cleared", 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
`endif

        // Let the monitor drain its queues, then check nothing is left over
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL exp_queue_left: got %0d entries, want 0", exp_q.size());
        end
        n_cmp = n_cmp + 1;
        if (ack_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL missing_ack: got %0d acks outstanding, want 0", ack_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Central pipeline sequencer for the 4-register in-order core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates stall requests (EX multi-cycle unit, MEM bus wait), branch/jump redirects and interrupt entry.
- Drives per-stage flush, which loads the default/bubble value into the pipe registers.
- Drives per-stage stall, which freezes the enable-controlled registers and the PC.
- Runs a small FSM that drains the pipe before vectoring to an interrupt.

Parameters:
- AW, 32, PC/address width.
- DRAIN_CYCLES, 3, bubble cycles inserted before interrupt entry (1..15).
- WDT_CYCLES, 255, bus-stall watchdog limit (only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- pc_i  in  AW  current fetch PC
- jump_req  in  1  redirect request from EX, level, held by requester until serviced
- jump_addr  in  AW  redirect target
- ex_stall_req  in  1  EX multi-cycle op busy
- bus_stall_req  in  1  MEM bus not ready
- irq_req  in  1  interrupt pending, level
- irq_vector  in  AW  interrupt handler address
- stall  out  4  bit k freezes pipe register k; PC freeze equals stall[0]
- flush  out  4  bit k loads bubble into pipe register k
- pc_we  out  1  PC write strobe
- pc_wdata  out  AW  PC write value
- irq_ack  out  1  one-cycle interrupt taken pulse
- irq_epc  out  AW  return address captured for the interrupt
- wdt_err  out  1  bus-stall timeout, sticky (feature only, else tied 0)

Behaviour:
- Reset (rst=1 at posedge): state=RUN, drain counter=0, irq_epc=0, wdt_err=0. Combinational outputs are 0 while state=RUN and all requests are low.
- stall, flush, pc_we and pc_wdata are combinational from state plus requests, with zero latency. irq_ack is a registered output.
- Priority in every state:
  1. bus_stall_req: stall=4'b0111, flush=4'b1000; everything else is ignored.
  2. ex_stall_req: stall=4'b0011, flush=4'b0100; jump is ignored.
  3. jump_req: flush=4'b0011, pc_we=1, pc_wdata=jump_addr.
- The same-cycle jump_req and irq_req rule is fixed as follows: in RUN, the jump is serviced and the IRQ waits one cycle.
- FSM states: RUN, DRAIN, ENTER.
- RUN -> DRAIN: irq_req=1 and no stall and no jump.
  - Capture irq_epc<=pc_i and cnt<=0.
  - Set stall[0]=1 (PC frozen) and flush[0]=1 during this cycle.
- DRAIN:
  - Each cycle with no stall: stall[0]=1, flush[0]=1, cnt<=cnt+1.
  - Any stall pauses cnt; the stall pattern from the priority list applies.
  - A jump in DRAIN (an older instruction redirecting) gives flush=4'b0011 and irq_epc<=jump_addr, with pc_we=0. cnt is not reset.
  - When cnt==DRAIN_CYCLES-1 and there is no stall: go to ENTER.
- ENTER: pc_we=1, pc_wdata=irq_vector, flush[1:0]=2'b11. irq_ack=1 on the next cycle. Go to RUN.
- irq_req dropping in DRAIN does not abort; entry still completes. Deasserting irq_req after irq_ack is the requester's job.
- rst mid-DRAIN or ENTER: return to RUN immediately with no irq_ack; irq_epc is cleared.

Optional Feature:
- Macro: PIPE_STALL_WDT_EN.
- Defined:
  - A counter increments on each consecutive bus_stall_req cycle and clears when the request is low.
  - Reaching WDT_CYCLES sets wdt_err=1; it is sticky until rst.
  - Stall behaviour is unchanged, so software or the bus must recover.
- Undefined: no counter logic; wdt_err is driven 0.

Decomposition:
- Package pipe_ctrl_defs holds:
  - stage index constants: IFID=0, IDEX=1, EXMEM=2, MEMWB=3
  - FSM state encodings RUN/DRAIN/ENTER (2 bits)
  - stall/flush pattern constants
  - DRAIN_CYCLES default
- One sub-module, pipe_stall_wdt (counter plus sticky flag), instantiated only under PIPE_STALL_WDT_EN.

Test Plan:
- Reset with rst=1, all requests high for 2 cycles, then rst=0 with requests low -> stall=0, flush=0, pc_we=0, irq_ack=0, irq_epc=0.
- jump_req=1, jump_addr=0x100 for 1 cycle -> same cycle flush=4'b0011, pc_we=1, pc_wdata=0x100. With ex_stall_req=1 simultaneously -> stall=4'b0011, flush=4'b0100, pc_we=0 until ex_stall_req drops.
- bus_stall_req and ex_stall_req both high for 5 cycles -> stall=4'b0111, flush=4'b1000 every cycle; no PC write.
- irq_req=1, pc_i=0x40, irq_vector=0x80, DRAIN_CYCLES=3 -> 3 bubble cycles then ENTER with pc_we=1 and pc_wdata=0x80; irq_ack pulses next cycle with irq_epc=0x40. A 2-cycle bus stall mid-drain extends the sequence by 2 cycles.
- Jump to 0x200 during DRAIN -> irq_epc=0x200, flush=4'b0011, pc_we=0; entry still occurs. rst asserted in DRAIN -> state RUN next cycle, no irq_ack.
- With PIPE_STALL_WDT_EN and WDT_CYCLES=255: bus_stall_req held 255 cycles -> wdt_err rises after the 255th cycle and stays high after the stall ends, until rst.
